// File: rtl/stream_serializer_pkg.sv
// Shared types and helpers for the wide-word to narrow-stream serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    SEND_PEND = 2'd2
  } t_ser_state;

  function automatic int unsigned calc_len_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_N_PARALLEL = 30;
  localparam int unsigned DEF_LEN_W      = calc_len_w(DEF_N_PARALLEL);

  // Zero or over-range lengths mean "send the whole word".
  function automatic int unsigned clamp_len(int unsigned len, int unsigned n);
    if (len == 0 || len > n) return n;
    return len;
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Parallel-word input and narrow-beat output handshakes of the serializer.
interface stream_serializer_if
  import serializer_pkg::*;
#(
  parameter int N_PARALLEL = 30,
  parameter int DATA_WIDTH = 16
) ();
  localparam int LEN_W = calc_len_w(N_PARALLEL);

  logic [N_PARALLEL*DATA_WIDTH-1:0] s_data;
  logic [LEN_W-1:0]                 s_len;
  logic                             s_valid;
  logic                             s_ready;
  logic [DATA_WIDTH-1:0]            m_data;
  logic                             m_valid;
  logic                             m_ready;
  logic                             m_last;

  // slave: the serializer itself; master: whoever feeds words and takes beats
  modport slave (
    input  s_data, s_len, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_len, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/stream_serializer_slot.sv
// One-deep frame holding register {word, len, valid}; load wins over clear.
module ser_frame_slot
  import serializer_pkg::*;
#(
  parameter int WORD_W = 480,
  parameter int LEN_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] d_word,
  input  logic [LEN_W-1:0]  d_len,
  output logic [WORD_W-1:0] q_word,
  output logic [LEN_W-1:0]  q_len,
  output logic              q_valid
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_valid <= 1'b0;
      q_word  <= '0;
      q_len   <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_word  <= d_word;
      q_len   <= d_len;
    end else if (clear) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// Serializes one N_PARALLEL-element word into DATA_WIDTH beats with backpressure and TLAST.
//
//   state     | meaning
//   IDLE      | no active frame (pending may hold a word about to load)
//   SEND      | active frame streaming, pending slot empty
//   SEND_PEND | active frame streaming, next frame waiting in pending
module stream_serializer
  import serializer_pkg::*;
#(
  parameter int N_PARALLEL = 30,
  parameter int DATA_WIDTH = 16,
  parameter int MSB_FIRST  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  stream_serializer_if.slave   bus,
  output logic                 o_busy
);

  localparam int LEN_W  = calc_len_w(N_PARALLEL);
  localparam int WORD_W = N_PARALLEL * DATA_WIDTH;

  t_ser_state        state_q, state_d;
  logic [WORD_W-1:0] act_buf;
  logic [LEN_W-1:0]  act_rem;
  logic              act_valid, act_valid_d;
  logic              pend_valid, pend_valid_d;
  logic [WORD_W-1:0] pend_word;
  logic [LEN_W-1:0]  pend_len;
  logic [LEN_W-1:0]  s_len_clamped;
  logic              s_ready_q;
  logic              accept, beat, last_beat, move;

  assign act_valid     = (state_q != IDLE);
  assign accept        = bus.s_valid && s_ready_q;
  assign beat          = act_valid && bus.m_ready;
  assign last_beat     = beat && (act_rem == LEN_W'(1));
  assign s_len_clamped = LEN_W'(clamp_len(32'(bus.s_len), N_PARALLEL));

  ser_frame_slot #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_pend_slot (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (accept),
    .clear   (move),
    .d_word  (bus.s_data),
    .d_len   (s_len_clamped),
    .q_word  (pend_word),
    .q_len   (pend_len),
    .q_valid (pend_valid)
  );

  always_comb begin
    move         = 1'b0;
    act_valid_d  = act_valid;
    pend_valid_d = pend_valid;
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (pend_valid) begin
          move        = 1'b1;
          act_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (last_beat) act_valid_d = 1'b0;
      end
      SEND_PEND: begin
        // last beat hands straight over to the pending frame: no bubble
        if (last_beat) move = 1'b1;
      end
      default: act_valid_d = 1'b0;
    endcase

    if (accept)    pend_valid_d = 1'b1;
    else if (move) pend_valid_d = 1'b0;

    if (!act_valid_d)     state_d = IDLE;
    else if (pend_valid_d) state_d = SEND_PEND;
    else                   state_d = SEND;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= !pend_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      act_buf <= '0;
      act_rem <= '0;
    end else if (move) begin
      act_buf <= pend_word;
      act_rem <= pend_len;
    end else if (beat) begin
      act_buf <= (MSB_FIRST != 0) ? (act_buf << DATA_WIDTH) : (act_buf >> DATA_WIDTH);
      act_rem <= act_rem - LEN_W'(1);
    end
  end

  assign bus.m_data  = (MSB_FIRST != 0) ? act_buf[WORD_W-1 -: DATA_WIDTH]
                                        : act_buf[DATA_WIDTH-1:0];
  assign bus.m_valid = act_valid;
  assign bus.m_last  = act_valid && (act_rem == LEN_W'(1));
  assign bus.s_ready = s_ready_q;
  assign o_busy      = act_valid || pend_valid;

endmodule
